product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulation stage directly downstream of the 4x4 combinational `multiplier`. It consumes the 8-bit product stream over a valid/ready handshake and sums a fixed-length block of COUNT products into a wide, saturating accumulator. It presents the block result on a held valid/ready output for the next stage. It turns the multiplier into a block-wise multiply-accumulate (dot-product) datapath.

## Interface
- PW, 8, product width; matches the multiplier output y
- AW, 16, accumulator/result width; must satisfy AW >= PW
- COUNT, 8, products per block; must be >= 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a new block; honoured only in IDLE
- in_valid  input  1  product is valid this cycle
- in_ready  output  1  block accepts a product this cycle
- product  input  PW  unsigned product from the multiplier
- out_valid  output  1  sum and overflow are valid
- out_ready  input  1  downstream accepts the result
- sum  output  AW  accumulated block result, unsigned
- overflow  output  1  set if saturation occurred during the block
- busy  output  1  high in ACCUM and DONE

## Operation
- Reset is asynchronous (clk and rst_n only) and active-low. Assertion forces state=IDLE, acc=0, cnt=0, ovf=0. Outputs go to in_ready=0, out_valid=0, sum=0, overflow=0, busy=0 immediately, without waiting for a clock edge.
- The state machine has three states: IDLE, ACCUM and DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - When start=1: clear acc, cnt and ovf, then go to ACCUM.
- ACCUM:
  - in_ready=1.
  - A product is accepted when in_valid and in_ready are both 1.
  - On each accept, acc is updated to acc + zero-extended product and cnt increments.
  - Saturation: if the true sum is >= 2^AW, acc becomes 2^AW-1 and ovf is set. ovf is sticky until the next start.
  - Once acc is saturated, further accepts still count but leave acc unchanged.
  - When the accept happens with cnt==COUNT-1, go to DONE.
  - Cycles with in_valid=0 are stalls: acc and cnt are unchanged.
- DONE:
  - out_valid=1, sum=acc, overflow=ovf, in_ready=0.
  - sum and overflow hold stable while out_valid=1 and out_ready=0.
  - When out_ready=1, go to IDLE.
- start is ignored in ACCUM and DONE. It never restarts or corrupts a block in progress.
- sum and overflow hold the last block's values in IDLE. They are only qualified by out_valid.
- The product input is consumed as-is; there is no input register. The upstream multiplier is combinational from registered operands.

## Timing
- start sampled high in IDLE puts the block in ACCUM, with in_ready=1, on the next cycle.
- Peak throughput is one product per cycle, so a block with no stalls completes in COUNT accept cycles.
- The result is visible on the cycle after the last accept: out_valid=1, and sum includes the last product.
- Total latency from start to out_valid is COUNT+1 cycles with no stalls.
- The handshake completes on the edge where out_valid and out_ready are both 1. out_valid drops the following cycle.
- The earliest the next block can begin is a start in the IDLE cycle after the handshake, i.e. one bubble cycle between blocks.
- When saturation and the last accept occur in the same cycle, the block enters DONE with overflow=1 and sum=2^AW-1.
- With COUNT=1, a single accept goes directly to DONE.
- Reset asserted in ACCUM or DONE abandons the block; no partial result is presented.

## Test plan
- Reset: assert rst_n=0 mid-clock with no edge -> all outputs 0 immediately. Release, hold start=0 for 5 cycles -> the block stays in IDLE with in_ready=0.
- Basic block (COUNT=8): start, then products 0,1,2,3,4,5,2,4 on consecutive cycles (a=1,b=0..5 and a=2,b=1..2) -> out_valid=1 exactly 9 cycles after start, sum=21, overflow=0.
- Stalls: same products with in_valid=0 inserted after the 2nd and 5th product -> sum=21, out_valid arrives 2 cycles later, and cnt does not advance on stall cycles.
- Saturation (AW=10, COUNT=8): eight products of 255 -> sum=1023, overflow=1. A following block of eight 1s -> sum=8, overflow=0, confirming ovf is cleared by start.
- Output backpressure: hold out_ready=0 for 4 cycles in DONE and pulse start there -> sum and overflow stable, start ignored. out_ready=1 -> IDLE next cycle, with no new block started.
- Reset mid-operation: assert rst_n after 3 accepts -> out_valid never asserts. A new start and 8 products of 1 -> sum=8.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: block-wise saturating accumulator for the multiplier product stream.
// Ports: i_clk/i_rst_n (async active-low) clock and reset; i_start begins a block in IDLE;
// i_in_valid/o_in_ready/i_product form the product handshake; o_out_valid/i_out_ready
// deliver o_sum/o_overflow; o_busy is high in ACCUM and DONE.
module product_accumulator #(
  parameter int PW    = 8,
  parameter int AW    = 16,
  parameter int COUNT = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [PW-1:0] i_product,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [AW-1:0] o_sum,
  output logic          o_overflow,
  output logic          o_busy
);
  localparam int CW = COUNT > 1 ? $clog2(COUNT) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t        r_state, w_next;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic [AW:0]   w_add;
  logic          w_accept, w_last;
  assign w_accept = (r_state == ACCUM) && i_in_valid;
  assign w_last   = r_cnt == CW'(COUNT - 1);
  // One extra bit exposes the carry; a saturated acc plus anything non-zero carries again,
  // so it stays pinned at all ones without a separate check.
  assign w_add    = {1'b0, r_acc} + {{(AW + 1 - PW){1'b0}}, i_product};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? ACCUM : IDLE;
      ACCUM:   w_next = (i_in_valid && w_last) ? DONE : ACCUM;
      DONE:    w_next = i_out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    o_in_ready  = r_state == ACCUM;
    o_out_valid = r_state == DONE;
    o_busy      = r_state != IDLE;
    o_sum       = r_acc;
    o_overflow  = r_ovf;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_add[AW] ? '1 : w_add[AW-1:0];
      r_ovf <= r_ovf | w_add[AW];
      r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed scoreboard bench for product_accumulator (AW=10, COUNT=8).
module tb_product_accumulator;
  localparam int PW = 8, AW = 10, COUNT = 8;
  logic          clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 1;
  logic [PW-1:0] product = '0;
  logic          in_ready, out_valid, overflow, busy;
  logic [AW-1:0] sum;
  typedef struct {int s; int o;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  product_accumulator #(.PW(PW), .AW(AW), .COUNT(COUNT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_product(product), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_sum(sum), .o_overflow(overflow), .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_sum", int'(sum), e.s);
        chk("sb_overflow", int'(overflow), e.o);
      end
    end
  task automatic run_block(input int p[8], input bit [7:0] st, input int es, input int eo,
                           input int elat, input bit bp);
    int t;
    int s0, o0;
    q.push_back('{es, eo});
    start = 1;
    tick;
    start = 0;
    t = 1;
    chk("accum_in_ready", int'(in_ready), 1);
    chk("accum_busy", int'(busy), 1);
    for (int k = 0; k < COUNT; k++) begin
      if (st[k]) begin
        in_valid = 0;
        tick;
        t++;
        chk("stall_in_ready", int'(in_ready), 1);
        chk("stall_no_done", int'(out_valid), 0);
      end
      in_valid = 1;
      product = PW'(p[k]);
      if (k == COUNT - 1 && bp) out_ready = 0;
      tick;
      t++;
    end
    in_valid = 0;
    for (int w = 0; w < 20 && !out_valid; w++) begin
      tick;
      t++;
    end
    chk("out_valid", int'(out_valid), 1);
    chk("latency", t, elat);
    chk("done_in_ready", int'(in_ready), 0);
    if (bp) begin
      s0 = int'(sum);
      o0 = int'(overflow);
      repeat (4) begin
        start = 1;
        tick;
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_sum_stable", int'(sum), s0);
        chk("bp_ovf_stable", int'(overflow), o0);
      end
      out_ready = 1;
    end
    tick;
    start = 0;
    chk("idle_out_valid", int'(out_valid), 0);
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_held_sum", int'(sum), es);
    chk("idle_held_ovf", int'(overflow), eo);
    tick;
    chk("idle_no_new_block", int'(in_ready), 0);
  endtask
  initial begin
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_busy", int'(busy), 0);
    tick;
    tick;
    rst_n = 1;
    repeat (5) begin
      tick;
      chk("idle_hold_ready", int'(in_ready), 0);
      chk("idle_hold_busy", int'(busy), 0);
    end
    run_block('{0, 1, 2, 3, 4, 5, 2, 4}, 8'h00, 21, 0, 9, 0);
    run_block('{0, 1, 2, 3, 4, 5, 2, 4}, 8'b0010_0100, 21, 0, 11, 0);
    start = 1;
    tick;
    start = 0;
    in_valid = 1;
    product = 1;
    repeat (3) tick;
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_sum", int'(sum), 0);
    chk("midrst_overflow", int'(overflow), 0);
    tick;
    rst_n = 1;
    repeat (10) begin
      tick;
      chk("midrst_no_result", int'(out_valid), 0);
    end
    run_block('{1, 1, 1, 1, 1, 1, 1, 1}, 8'h00, 8, 0, 9, 0);
    run_block('{255, 255, 255, 255, 255, 255, 255, 255}, 8'h00, 1023, 1, 9, 1);
    run_block('{1, 1, 1, 1, 1, 1, 1, 1}, 8'h00, 8, 0, 9, 0);
    run_block('{200, 200, 200, 200, 200, 23, 0, 1}, 8'h00, 1023, 1, 9, 0);
    repeat (3) tick;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
